// File: rtl/button_event_reader_pkg.sv
// Shared definitions for the button event reader: colour codes, MMIO addresses,
// event-word bit positions and the FIFO entry format.
package button_event_reader_pkg;

    localparam int NUM_BTN = 4;

    typedef enum logic [1:0] {
        COL_RED    = 2'b00,
        COL_BLUE   = 2'b01,
        COL_GREEN  = 2'b10,
        COL_YELLOW = 2'b11
    } color_e;

    localparam logic [31:0] ADDR_RANDOM = 32'd5;
    localparam logic [31:0] ADDR_LED    = 32'd6;
    localparam logic [31:0] ADDR_BUTTON = 32'd7;

    localparam int EV_VALID    = 31;
    localparam int EV_OVF      = 30;
    localparam int EV_RELEASE  = 3;
    localparam int EV_COLOR_HI = 2;
    localparam int EV_COLOR_LO = 1;
    localparam int EV_ON       = 0;

    typedef struct packed {
        logic   rel;
        color_e color;
    } fifo_entry_t;

    // Same layout as the LED store word: a press lights the LED, a release clears it.
    function automatic logic [31:0] make_event(input fifo_entry_t e, input logic ovf);
        logic [31:0] w;
        w = '0;
        w[EV_VALID]                = 1'b1;
        w[EV_OVF]                  = ovf;
        w[EV_RELEASE]              = e.rel;
        w[EV_COLOR_HI:EV_COLOR_LO] = e.color;
        w[EV_ON]                   = ~e.rel;
        return w;
    endfunction

endpackage

// File: rtl/button_event_reader_button_debounce.sv
// Per-button 2-flop synchronizer and stability-counter debouncer.
// Emits a one-cycle press pulse (and a release pulse when RELEASE_EVENTS_EN is defined).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
`ifdef RELEASE_EVENTS_EN
    ,
    output logic release_pulse
`endif
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        level_d = level_q;
        cnt_d   = cnt_q;
        flip    = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            flip    = 1'b1;
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign press_pulse = flip & sync_q[1];
`ifdef RELEASE_EVENTS_EN
    assign release_pulse = flip & ~sync_q[1];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_reader.sv
// Debounced game-button event queue popped by CPU loads from address 7.
// Optional macro RELEASE_EVENTS_EN adds release events after all press events.
module button_event_reader
    import button_event_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        green_button,
    input  logic        yellow_button,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        event_pending,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

`ifdef RELEASE_EVENTS_EN
    localparam int NREQ = 2 * NUM_BTN;
`else
    localparam int NREQ = NUM_BTN;
`endif

    // Index order doubles as colour code and arbitration priority.
    logic [NUM_BTN-1:0] btn_raw, press;
    assign btn_raw = {yellow_button, green_button, blue_button, red_button};

`ifdef RELEASE_EVENTS_EN
    logic [NUM_BTN-1:0] release_p;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock        (clock),
            .reset        (reset),
            .btn_raw      (btn_raw[i]),
            .press_pulse  (press[i])
`ifdef RELEASE_EVENTS_EN
            ,
            .release_pulse(release_p[i])
`endif
        );
    end

    logic [NREQ-1:0] new_req;
`ifdef RELEASE_EVENTS_EN
    assign new_req = {release_p, press};
`else
    assign new_req = press;
`endif

    logic [NREQ-1:0]                    pend_q, pend_d, grant;
    fifo_entry_t [FIFO_DEPTH-1:0]       mem_q, mem_d;
    logic [PW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                               ovf_q, ovf_d;
    fifo_entry_t                        push_entry;
    logic                               push, pop, accept, drop, empty, full;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Lowest set pending bit wins; a granted bit is consumed whether it lands or is dropped.
    always_comb begin
        grant      = pend_q & (~pend_q + 1'b1);
        push       = |pend_q;
        push_entry = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                push_entry.color = color_e'(i[1:0]);
`ifdef RELEASE_EVENTS_EN
                push_entry.rel   = (i >= NUM_BTN);
`endif
            end
        end
    end

    assign pop    = rd_en & ~empty;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_comb begin
        pend_d   = (pend_q & ~grant) | new_req;
        mem_d    = mem_q;
        if (accept) mem_d[wr_ptr_q[AW-1:0]] = push_entry;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, accept};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        ovf_d    = ovf_q;
        if (pop)       ovf_d = 1'b0;
        else if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q   <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_data       = empty ? 32'h0 : make_event(mem_q[rd_ptr_q[AW-1:0]], ovf_q);
    assign event_pending = ~empty;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_button_event_reader.sv
// Randomized scoreboard bench for button_event_reader (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
module tb_button_event_reader;
    localparam int DC    = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        red_button = 1'b0, blue_button = 1'b0, green_button = 1'b0, yellow_button = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        event_pending, overflow;

    button_event_reader #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .red_button(red_button), .blue_button(blue_button),
        .green_button(green_button), .yellow_button(yellow_button),
        .rd_en(rd_en), .rd_data(rd_data),
        .event_pending(event_pending), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int sb[$];        // queued events: colour + 4*release, oldest first
    bit m_ovf = 1'b0; // reference sticky overflow
    int lat   = 7;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ev_word(input int code, input bit ovf);
        int col, rel;
        logic [31:0] w;
        col = code % 4;
        rel = code / 4;
        w = 32'h8000_0000;
        if (ovf) w = w + 32'h4000_0000;
        w = w + 32'(rel * 8 + col * 2 + (1 - rel));
        return w;
    endfunction

    task automatic model_push(input int code);
        if (sb.size() >= DEPTH) m_ovf = 1'b1;
        else sb.push_back(code);
    endtask

    task automatic set_buttons(input logic [3:0] m);
        red_button = m[0]; blue_button = m[1]; green_button = m[2]; yellow_button = m[3];
    endtask

    // Hold the mask 12 cycles, release, settle 12 cycles; rise = cycle event_pending was first seen.
    task automatic press(input logic [3:0] mask, output int rise);
        rise = -1;
        @(posedge clock); #1;
        set_buttons(mask);
        for (int b = 0; b < 4; b++) if (mask[b]) model_push(b);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock); #1;
            if (rise < 0 && event_pending) rise = k;
        end
        set_buttons(4'b0);
`ifdef RELEASE_EVENTS_EN
        for (int b = 0; b < 4; b++) if (mask[b]) model_push(b + 4);
`endif
        repeat (12) @(posedge clock);
        #1;
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1; rd_en = 1'b1;
            @(posedge clock); #1; rd_en = 1'b0;
        end
    endtask

    task automatic check_state(input string name);
        @(negedge clock);
        chk({name, "_pending"}, {31'b0, event_pending}, {31'b0, sb.size() != 0});
        chk({name, "_overflow"}, {31'b0, overflow}, {31'b0, m_ovf});
        chk({name, "_rd_data"}, rd_data, (sb.size() != 0) ? ev_word(sb[0], m_ovf) : 32'h0);
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && rd_en && event_pending) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got %h expected no event", rd_data);
                end else begin
                    chk("pop_word", rd_data, ev_word(sb[0], m_ovf));
                    void'(sb.pop_front());
                    m_ovf = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int r;
        // Reset state
        #1;
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_pending", {31'b0, event_pending}, 32'h0);
        chk("reset_overflow", {31'b0, overflow}, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1'b1;

        // Single green press, also measuring raw-edge to push latency
        press(4'b0100, r);
        chk("latency_found", {31'b0, r > 0}, 32'h1);
        if (r > 0) lat = r;
        check_state("single");
        read_n(1);
        check_state("single_after");

        // Bounce on blue: no run long enough to be accepted
        @(posedge clock); #1;
        for (int t = 0; t < 6; t++) begin
            blue_button = ~blue_button;
            repeat (2) @(posedge clock);
            #1;
        end
        blue_button = 1'b0;
        repeat (20) @(posedge clock);
        check_state("bounce");

        // Simultaneous red + yellow
        press(4'b1001, r);
        check_state("simul");
        read_n(2);
        check_state("simul_after");

        // Overflow: five presses, no reads
        press(4'b0001, r); press(4'b0010, r); press(4'b0100, r); press(4'b1000, r);
        press(4'b0001, r);
        check_state("ovf_full");
        read_n(1);
        check_state("ovf_cleared");
        read_n(DEPTH + 4);
        check_state("ovf_drained");

        // Full FIFO: a push commits on the same edge as a pop
        press(4'b0001, r); press(4'b0010, r); press(4'b0100, r); press(4'b1000, r);
        check_state("pp_full");
        @(posedge clock); #1; yellow_button = 1'b1;
        repeat (lat - 1) @(posedge clock);
        #1; rd_en = 1'b1;
        @(posedge clock); #1; rd_en = 1'b0;
        model_push(3);
        repeat (8) @(posedge clock);
        #1; yellow_button = 1'b0;
`ifdef RELEASE_EVENTS_EN
        model_push(7);
`endif
        repeat (12) @(posedge clock);
        check_state("pp_after");
        read_n(DEPTH + 4);
        check_state("pp_drained");

        // rd_en on an empty FIFO is ignored
        read_n(2);
        check_state("empty_read");
        press(4'b0010, r);
        check_state("empty_read_push");

        // Asynchronous reset with events queued
        press(4'b0001, r);
        check_state("pre_reset");
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        chk("async_reset_rd_data", rd_data, 32'h0);
        chk("async_reset_pending", {31'b0, event_pending}, 32'h0);
        chk("async_reset_overflow", {31'b0, overflow}, 32'h0);
        sb.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        check_state("post_reset");

        // Randomized presses, glitches and reads
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clock); #1;
                set_buttons(4'(1 << $urandom_range(0, 3)));
                repeat ($urandom_range(1, 2)) @(posedge clock);
                #1; set_buttons(4'b0);
                repeat (8) @(posedge clock);
            end
            press(4'($urandom_range(1, 15)), r);
            if ($urandom_range(0, 1) == 1) read_n($urandom_range(1, 4));
            check_state("rand");
        end
        read_n(DEPTH + 4);
        check_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
